// File: rtl/instr_sequencer.sv
// Instruction sequencer: issues words from a loadable program memory to the FSM
// processor using its run/done handshake, with a done-timeout watchdog.
module instr_sequencer #(
  parameter int DEPTH   = 16,
  parameter int AW      = $clog2(DEPTH),
  parameter int TIMEOUT = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [15:0]   load_data,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  output logic [15:0]   instr_out,
  output logic          run,
  input  logic          done,
  output logic          busy,
  output logic          finished,
  output logic          timeout_err,
  output logic [AW-1:0] pc,
  output logic [1:0]    dbg_state
);

  // Handshake: run is a single-cycle strobe that presents instr_out; the processor
  // answers with a single-cycle done, which is only sampled while waiting for it.
  // instr_out stays constant from the run cycle up to and including the done cycle.

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_FIN   = 2'd3
  } state_e;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   DEPTH_W   = (AW+1)'(DEPTH);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [15:0]   instr_q, instr_d;
  logic [AW:0]   len_q, len_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          terr_q, terr_d;

  logic [15:0]   mem_q [DEPTH];

  logic [AW-1:0] pc_inc;
  logic [AW:0]   pc_inc_w;
  logic [AW:0]   len_clamped;

  assign pc_inc      = pc_q + AW'(1);
  assign pc_inc_w    = {1'b0, pc_q} + (AW+1)'(1);
  assign len_clamped = (prog_len > DEPTH_W) ? DEPTH_W : prog_len;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
      len_q   <= '0;
      timer_q <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      len_q   <= len_d;
      timer_q <= timer_d;
      terr_q  <= terr_d;
    end
  end

  // Program memory survives reset; writes are locked out while a program runs.
  always_ff @(posedge clk) begin
    if (load_en && !busy) begin
      mem_q[load_addr] <= load_data;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    len_d    = len_q;
    timer_d  = timer_q;
    terr_d   = terr_q;
    run      = 1'b0;
    busy     = 1'b0;
    finished = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (prog_len == '0) begin
            state_d = S_FIN;
          end else begin
            pc_d    = '0;
            instr_d = mem_q[0];
            len_d   = len_clamped;
            terr_d  = 1'b0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        run     = 1'b1;
        busy    = 1'b1;
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        busy    = 1'b1;
        timer_d = timer_q + TW'(1);
        // done wins over an expiring timer in the same cycle
        if (done) begin
          if (pc_inc_w == len_q) begin
            state_d = S_FIN;
          end else begin
            pc_d    = pc_inc;
            instr_d = mem_q[pc_inc];
            state_d = S_ISSUE;
          end
        end else if (timer_q == TIMER_MAX) begin
          terr_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_FIN: begin
        finished = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign instr_out   = instr_q;
  assign timeout_err = terr_q;
  assign pc          = pc_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Randomised bench for instr_sequencer: a responder answers run with done after a
// chosen latency; a program-level model predicts every run, finish and timeout.
module tb_instr_sequencer;
  localparam int DEPTH   = 16;
  localparam int AW      = 4;
  localparam int TIMEOUT = 8;
  localparam int RW      = 32 + AW + 16;
  localparam int EW      = 33;
  localparam int NODONE  = 999;

  logic          clk = 1'b0;
  logic          reset, load_en, start, done;
  logic [AW-1:0] load_addr;
  logic [15:0]   load_data;
  logic [AW:0]   prog_len;
  logic [15:0]   instr_out;
  logic          run, busy, finished, timeout_err;
  logic [AW-1:0] pc;
  logic [1:0]    dbg_state;

  instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .prog_len(prog_len),
    .instr_out(instr_out), .run(run), .done(done), .busy(busy),
    .finished(finished), .timeout_err(timeout_err), .pc(pc), .dbg_state(dbg_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state
  logic [RW-1:0]      exp_q[$];      // {run cycle, pc, instr}
  logic [EW-1:0]      exp_evt_q[$];  // {kind: 0 finished / 1 timeout, cycle}
  int                 lat_q[$];      // done latency per issued instruction
  logic [15:0]        mem_model[DEPTH];
  logic [AW+15:0]     cur_exp = '0;
  bit                 to_prev = 1'b0;
  bit                 spur_en = 1'b0;
  int                 n_checks = 0;
  int                 n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // responder: done arrives L cycles after the run cycle; optional ignored done during run
  initial begin
    int lat;
    done = 1'b0;
    forever begin
      @(negedge clk);
      done = 1'b0;
      if (run === 1'b1) begin
        lat = (lat_q.size() > 0) ? lat_q.pop_front() : NODONE;
        if (spur_en) done = 1'b1;
        if (lat <= TIMEOUT) begin
          @(negedge clk);
          done = 1'b0;
          repeat (lat - 1) @(negedge clk);
          done = 1'b1;
        end
      end
    end
  end

  // monitor
  initial begin
    logic [RW-1:0] e;
    logic [EW-1:0] ev;
    forever begin
      @(negedge clk);
      if (run === 1'b1) begin
        check("run_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("run_cycle", 32'(cyc), e[RW-1:AW+16]);
          check("run_pc_instr", {pc, instr_out}, e[AW+15:0]);
          cur_exp = e[AW+15:0];
        end
      end else if (busy === 1'b1) begin
        check("hold_pc_instr", {pc, instr_out}, cur_exp);
      end
      if (finished === 1'b1) begin
        check("fin_expected", exp_evt_q.size() > 0, 1);
        if (exp_evt_q.size() > 0) begin
          ev = exp_evt_q.pop_front();
          check("fin_event", {1'b0, 32'(cyc)}, ev);
        end
      end
      if (timeout_err === 1'b1 && !to_prev) begin
        check("timeout_expected", exp_evt_q.size() > 0, 1);
        if (exp_evt_q.size() > 0) begin
          ev = exp_evt_q.pop_front();
          check("timeout_event", {1'b1, 32'(cyc)}, ev);
        end
      end
      to_prev = (timeout_err === 1'b1);
    end
  end

  // driver tasks
  task automatic load_word(input logic [AW-1:0] a, input logic [15:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    mem_model[a] = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic start_prog(input int plen, input bit with_load,
                            input logic [AW-1:0] la, input logic [15:0] ld);
    int k, n, r, lat;
    int lats[$];
    @(negedge clk);
    lats = lat_q;
    k = cyc;
    start = 1'b1;
    prog_len = plen[AW:0];
    if (with_load) begin
      load_en = 1'b1; load_addr = la; load_data = ld;
    end
    n = (plen > DEPTH) ? DEPTH : plen;
    if (n == 0) begin
      exp_evt_q.push_back({1'b0, 32'(k + 1)});
    end else begin
      r = k + 1;
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({32'(r), AW'(i), mem_model[i]});
        lat = (i < lats.size()) ? lats[i] : NODONE;
        if (lat > TIMEOUT) begin
          exp_evt_q.push_back({1'b1, 32'(r + TIMEOUT + 1)});
          break;
        end
        if (i == n - 1) exp_evt_q.push_back({1'b0, 32'(r + lat + 1)});
        r = r + lat + 1;
      end
    end
    if (with_load) mem_model[la] = ld;
    @(negedge clk);
    start = 1'b0;
    load_en = 1'b0;
  endtask

  task automatic go(input int plen);
    start_prog(plen, 1'b0, '0, '0);
  endtask

  task automatic wait_drain();
    int b = 0;
    while ((exp_q.size() != 0 || exp_evt_q.size() != 0) && b < 600) begin
      @(negedge clk);
      b++;
    end
    check("drain_in_budget", b < 600, 1);
    if (b >= 600) begin
      exp_q.delete();
      exp_evt_q.delete();
    end
    repeat (3) @(negedge clk);
    lat_q.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instr"}, instr_out, 16'h0000);
    check({tag, "_run"}, run, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_finished"}, finished, 1'b0);
    check({tag, "_timeout"}, timeout_err, 1'b0);
    check({tag, "_pc"}, pc, '0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: simulation did not finish");
    $fatal(1, "time limit");
  end

  // main sequence
  initial begin
    int b;
    reset = 1'b1; load_en = 1'b0; start = 1'b0;
    load_addr = '0; load_data = '0; prog_len = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    check("rst_state", dbg_state, 2'd0);
    reset = 1'b0;

    for (int i = 0; i < DEPTH; i++) load_word(AW'(i), 16'($urandom));

    // four-instruction program
    load_word(0, 16'h2005); load_word(1, 16'h6003);
    load_word(2, 16'hE004); load_word(3, 16'h1000);
    lat_q = '{2, 4, 4, 4};
    go(4);
    wait_drain();
    check("pc_after_fin", pc, 4'd3);

    // empty program: only finished
    go(0);
    wait_drain();
    check("busy_after_empty", busy, 1'b0);

    // no done at all: watchdog
    go(1);
    wait_drain();
    repeat (4) @(negedge clk);
    check("timeout_sticky", timeout_err, 1'b1);
    check("busy_after_timeout", busy, 1'b0);
    lat_q = '{1};
    go(1);
    check("timeout_cleared", timeout_err, 1'b0);
    wait_drain();

    // mv-only program
    load_word(0, 16'h2007); load_word(1, 16'h3009);
    lat_q = '{2, 2};
    go(2);
    wait_drain();

    // done on the last allowed wait cycle beats the watchdog
    lat_q = '{TIMEOUT, 1};
    go(2);
    wait_drain();
    check("no_timeout_at_limit", timeout_err, 1'b0);

    // disturbances while busy: load, start, done during run cycle
    lat_q = '{6, 6};
    spur_en = 1'b1;
    go(2);
    @(negedge clk);
    load_en = 1'b1; load_addr = 0; load_data = ~mem_model[0];
    start = 1'b1; prog_len = 1;
    @(negedge clk);
    load_en = 1'b0; start = 1'b0;
    wait_drain();
    spur_en = 1'b0;
    lat_q = '{1, 1};
    go(2);
    wait_drain();

    // load and start together in idle: old word issued, new word stored
    lat_q = '{1};
    start_prog(1, 1'b1, 0, 16'hBEEF);
    wait_drain();
    lat_q = '{1};
    go(1);
    wait_drain();

    // reset during the wait of the second instruction
    lat_q = '{3, 6, 3};
    go(3);
    b = 0;
    while (!(run === 1'b1 && pc == 4'd1) && b < 50) begin
      @(negedge clk);
      b++;
    end
    check("second_run_seen", b < 50, 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    exp_q.delete(); exp_evt_q.delete(); lat_q.delete();
    @(negedge clk);
    check_reset_outputs("midrst");
    reset = 1'b0;
    repeat (12) @(negedge clk);
    lat_q = '{1, 2, 3};
    go(3);
    wait_drain();

    // randomised programs, including clamped lengths and timeouts
    for (int it = 0; it < 8; it++) begin
      int plen;
      for (int i = 0; i < DEPTH; i++) load_word(AW'(i), 16'($urandom));
      plen = $urandom_range(0, 31);
      for (int i = 0; i < DEPTH; i++)
        lat_q.push_back(($urandom_range(0, 9) == 0) ? NODONE : $urandom_range(1, TIMEOUT));
      spur_en = $urandom_range(0, 1);
      go(plen);
      wait_drain();
    end
    spur_en = 1'b0;

    check("queues_empty", exp_q.size() + exp_evt_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
